// File: rtl/multi_domain_power_sequencer.sv
// rtl/multi_domain_power_sequencer.sv - per-domain power gating FSMs sharing one round-robin inrush token
module multi_domain_power_sequencer #(
    parameter int                     NUM_DOMAINS    = 8,
    parameter int                     IDLE_CNT_W     = 16,
    parameter int                     ISO_CYCLES     = 4,
    parameter int                     ACK_TIMEOUT    = 64,
    parameter logic [NUM_DOMAINS-1:0] ALWAYS_ON_MASK = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_DOMAINS-1:0]         gate_req,
    input  logic [NUM_DOMAINS-1:0]         activity,
    input  logic [IDLE_CNT_W-1:0]          idle_threshold,
    input  logic [NUM_DOMAINS-1:0]         pwr_ack,
    input  logic                           err_clr,
    output logic [NUM_DOMAINS-1:0]         power_enable,
    output logic [NUM_DOMAINS-1:0]         isolation_enable,
    output logic [NUM_DOMAINS-1:0]         domain_on,
    output logic                           transition_busy,
    output logic [$clog2(NUM_DOMAINS)-1:0] active_domain,
    output logic [NUM_DOMAINS-1:0]         ack_err
);

    localparam int AW   = $clog2(NUM_DOMAINS);
    localparam int TMAX = (ISO_CYCLES > ACK_TIMEOUT) ? ISO_CYCLES : ACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ISO_LAST = TW'(ISO_CYCLES - 1);
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_ON, ST_ISO, ST_PWR_DN, ST_OFF, ST_PWR_UP, ST_DE_ISO
    } state_t;

    state_t                  st     [NUM_DOMAINS];
    state_t                  st_nxt [NUM_DOMAINS];
    logic [IDLE_CNT_W-1:0]   idle_cnt [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0]  off_cand, on_cand, err_set;
    logic [TW-1:0]           timer, timer_nxt;
    logic                    busy_nxt;
    logic [AW-1:0]           act_nxt, ptr, ptr_nxt, rr_pick, grant_idx;
    logic                    grant_found;
    int                      rr_idx;

    always_comb begin
        st_nxt      = st;
        timer_nxt   = timer;
        busy_nxt    = transition_busy;
        act_nxt     = active_domain;
        ptr_nxt     = ptr;
        err_set     = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        rr_pick     = '0;
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            off_cand[d] = (st[d] == ST_ON) && gate_req[d] && !activity[d] && !ALWAYS_ON_MASK[d]
                          && (idle_threshold != '0) && (idle_cnt[d] >= idle_threshold);
            on_cand[d]  = (st[d] == ST_OFF) && (activity[d] || !gate_req[d]);
        end
        if (transition_busy) begin
            // only the token holder advances; the shared timer belongs to it
            case (st[active_domain])
                ST_ISO: begin
                    if (activity[active_domain] || !gate_req[active_domain]) begin
                        st_nxt[active_domain] = ST_DE_ISO;
                        timer_nxt = '0;
                    end else if (timer == ISO_LAST) begin
                        st_nxt[active_domain] = ST_PWR_DN;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                ST_PWR_DN: begin
                    if (!pwr_ack[active_domain] || timer == ACK_LAST) begin
                        st_nxt[active_domain]  = ST_OFF;
                        err_set[active_domain] = pwr_ack[active_domain];
                        timer_nxt = '0;
                        busy_nxt  = 1'b0;
                        act_nxt   = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                ST_PWR_UP: begin
                    if (pwr_ack[active_domain] || timer == ACK_LAST) begin
                        st_nxt[active_domain]  = ST_DE_ISO;
                        err_set[active_domain] = !pwr_ack[active_domain];
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                ST_DE_ISO: begin
                    if (timer == ISO_LAST) begin
                        st_nxt[active_domain] = ST_ON;
                        timer_nxt = '0;
                        busy_nxt  = 1'b0;
                        act_nxt   = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                default: ;
            endcase
        end else begin
            for (int k = 1; k <= NUM_DOMAINS; k++) begin
                rr_idx = int'(ptr) + k;
                if (rr_idx >= NUM_DOMAINS) rr_idx = rr_idx - NUM_DOMAINS;
                rr_pick = AW'(rr_idx);
                if (!grant_found && (off_cand[rr_pick] || on_cand[rr_pick])) begin
                    grant_found = 1'b1;
                    grant_idx   = rr_pick;
                end
            end
            if (grant_found) begin
                st_nxt[grant_idx] = on_cand[grant_idx] ? ST_PWR_UP : ST_ISO;
                timer_nxt = '0;
                busy_nxt  = 1'b1;
                act_nxt   = grant_idx;
                ptr_nxt   = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                st[d]       <= ST_ON;
                idle_cnt[d] <= '0;
            end
            power_enable     <= '1;
            isolation_enable <= '0;
            domain_on        <= '1;
            ack_err          <= '0;
            timer            <= '0;
            transition_busy  <= 1'b0;
            active_domain    <= '0;
            ptr              <= AW'(NUM_DOMAINS - 1);
        end else begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                st[d]               <= st_nxt[d];
                power_enable[d]     <= !(st_nxt[d] == ST_PWR_DN || st_nxt[d] == ST_OFF);
                isolation_enable[d] <= (st_nxt[d] != ST_ON);
                domain_on[d]        <= (st_nxt[d] == ST_ON);
                if (activity[d] || st[d] != ST_ON)
                    idle_cnt[d] <= '0;
                else if (idle_cnt[d] != '1)
                    idle_cnt[d] <= idle_cnt[d] + IDLE_CNT_W'(1);
            end
            // a timeout in the same cycle as err_clr must survive the clear
            ack_err         <= (err_clr ? '0 : ack_err) | err_set;
            timer           <= timer_nxt;
            transition_busy <= busy_nxt;
            active_domain   <= act_nxt;
            ptr             <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_multi_domain_power_sequencer.sv
// tb/tb_multi_domain_power_sequencer.sv - directed checks of gating, abort, arbitration, timeout and no-gate cases
module tb_multi_domain_power_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gate_req, activity, pwr_ack;
    logic [15:0] idle_threshold;
    logic       err_clr;
    logic [3:0] power_enable, isolation_enable, domain_on, ack_err;
    logic       transition_busy;
    logic [1:0] active_domain;

    logic [3:0] ao_gate_req, ao_activity;
    logic [3:0] ao_power_enable, ao_isolation_enable, ao_domain_on, ao_ack_err;
    logic       ao_transition_busy;
    logic [1:0] ao_active_domain;

    logic [3:0] en_d1, en_d2, en_d3, stuck;
    int checks = 0;
    int errors = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    multi_domain_power_sequencer #(
        .NUM_DOMAINS(4), .IDLE_CNT_W(16), .ISO_CYCLES(2), .ACK_TIMEOUT(8), .ALWAYS_ON_MASK(4'b0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gate_req(gate_req), .activity(activity),
        .idle_threshold(idle_threshold), .pwr_ack(pwr_ack), .err_clr(err_clr),
        .power_enable(power_enable), .isolation_enable(isolation_enable), .domain_on(domain_on),
        .transition_busy(transition_busy), .active_domain(active_domain), .ack_err(ack_err)
    );

    multi_domain_power_sequencer #(
        .NUM_DOMAINS(4), .IDLE_CNT_W(16), .ISO_CYCLES(2), .ACK_TIMEOUT(8), .ALWAYS_ON_MASK(4'b0001)
    ) dut_ao (
        .clk(clk), .rst_n(rst_n), .gate_req(ao_gate_req), .activity(ao_activity),
        .idle_threshold(idle_threshold), .pwr_ack(ao_power_enable), .err_clr(err_clr),
        .power_enable(ao_power_enable), .isolation_enable(ao_isolation_enable), .domain_on(ao_domain_on),
        .transition_busy(ao_transition_busy), .active_domain(ao_active_domain), .ack_err(ao_ack_err)
    );

    // rail model: acknowledge follows enable three cycles later, optionally stuck high
    always @(posedge clk) begin
        if (!rst_n) begin
            en_d1 <= 4'hF; en_d2 <= 4'hF; en_d3 <= 4'hF;
        end else begin
            en_d1 <= power_enable; en_d2 <= en_d1; en_d3 <= en_d2;
        end
    end
    assign pwr_ack = en_d3 | stuck;

    always @(negedge clk)
        if (rst_n && $countones(power_enable & isolation_enable) > 1) overlap++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_all_on(input string tag, input int budget);
        int n = 0;
        while ((domain_on !== 4'hF || transition_busy !== 1'b0) && n < budget) begin
            tick(1);
            n++;
        end
        chk({tag, "_domain_on"}, domain_on, 4'hF);
        chk({tag, "_busy"}, transition_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; gate_req = 4'h0; activity = 4'hF; idle_threshold = 16'd10;
        err_clr = 1'b0; stuck = 4'h0; ao_gate_req = 4'h0; ao_activity = 4'hF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_power_enable", power_enable, 4'hF);
        chk("rst_isolation", isolation_enable, 4'h0);
        chk("rst_busy", transition_busy, 1'b0);
        chk("rst_ack_err", ack_err, 4'h0);
        chk("rst_domain_on", domain_on, 4'hF);
        chk("rst_active", active_domain, 2'd0);
        chk("rst_ao_power_enable", ao_power_enable, 4'hF);

        // gate domain 1: threshold reached after 10 idle edges, grant on the 11th
        gate_req = 4'b0010; activity = 4'b1101;
        tick(10);
        chk("gate_pre_iso", isolation_enable, 4'h0);
        chk("gate_pre_busy", transition_busy, 1'b0);
        tick(1);
        chk("gate_iso_up", isolation_enable, 4'b0010);
        chk("gate_busy", transition_busy, 1'b1);
        chk("gate_active", active_domain, 2'd1);
        chk("gate_pe_in_iso", power_enable, 4'hF);
        tick(1);
        chk("gate_pe_iso2", power_enable, 4'hF);
        tick(1);
        chk("gate_pe_drop", power_enable, 4'b1101);
        tick(3);
        chk("gate_pwrdn_busy", transition_busy, 1'b1);
        tick(1);
        chk("gate_off_busy", transition_busy, 1'b0);
        chk("gate_off_domain_on", domain_on, 4'b1101);
        chk("gate_off_iso", isolation_enable, 4'b0010);
        tick(5);
        chk("gate_stays_off", domain_on, 4'b1101);

        // wake domain 1 via activity
        activity = 4'hF;
        tick(1);
        chk("wake_pe_up", power_enable, 4'hF);
        chk("wake_iso_held", isolation_enable, 4'b0010);
        chk("wake_busy", transition_busy, 1'b1);
        tick(5);
        chk("wake_deiso_iso", isolation_enable, 4'b0010);
        tick(1);
        chk("wake_iso_drop", isolation_enable, 4'h0);
        chk("wake_domain_on", domain_on, 4'hF);
        chk("wake_busy_free", transition_busy, 1'b0);

        // abort: activity returns while domain 1 sits in ISO
        activity = 4'b1101;
        tick(11);
        chk("abort_iso", isolation_enable, 4'b0010);
        activity = 4'hF;
        tick(1);
        chk("abort_pe1", power_enable, 4'hF);
        chk("abort_deiso_busy", transition_busy, 1'b1);
        tick(1);
        chk("abort_pe2", power_enable, 4'hF);
        tick(1);
        chk("abort_on", domain_on, 4'hF);
        chk("abort_iso_off", isolation_enable, 4'h0);
        chk("abort_busy_free", transition_busy, 1'b0);

        // move the round-robin pointer to 0 by cycling domain 0
        gate_req = 4'b0001; activity = 4'b1110;
        tick(11);
        chk("ptr_active0", active_domain, 2'd0);
        tick(6);
        chk("ptr_off0", domain_on, 4'b1110);
        activity = 4'hF;
        tick(7);
        chk("ptr_on0", domain_on, 4'hF);

        // domains 0,2,3 become candidates together; expected grant order 2,3,0
        gate_req = 4'b1101; activity = 4'b0010;
        tick(11);
        chk("arb_first", active_domain, 2'd2);
        chk("arb_first_iso", isolation_enable, 4'b0100);
        tick(6);
        chk("arb_first_done", transition_busy, 1'b0);
        chk("arb_first_off", domain_on, 4'b1011);
        tick(1);
        chk("arb_second", active_domain, 2'd3);
        chk("arb_second_busy", transition_busy, 1'b1);
        tick(6);
        chk("arb_second_off", domain_on, 4'b0011);
        tick(1);
        chk("arb_third", active_domain, 2'd0);
        tick(6);
        chk("arb_third_off", domain_on, 4'b0010);
        chk("arb_third_pe", power_enable, 4'b0010);
        activity = 4'hF; gate_req = 4'h0;
        wait_all_on("arb_wake", 80);

        // acknowledge timeout on domain 2 with its rail stuck up
        stuck = 4'b0100; gate_req = 4'b0100; activity = 4'b1011;
        tick(11);
        chk("to_active", active_domain, 2'd2);
        tick(2);
        chk("to_pe_drop", power_enable, 4'b1011);
        tick(7);
        chk("to_err_early", ack_err, 4'h0);
        chk("to_busy_early", transition_busy, 1'b1);
        tick(1);
        chk("to_err_set", ack_err, 4'b0100);
        chk("to_off", domain_on, 4'b1011);
        chk("to_busy_free", transition_busy, 1'b0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("to_err_clr", ack_err, 4'h0);
        stuck = 4'h0; activity = 4'hF;
        wait_all_on("to_wake", 40);

        // zero threshold disables gating; counters keep running
        idle_threshold = 16'd0; gate_req = 4'hF; activity = 4'h0;
        tick(30);
        chk("thr0_domain_on", domain_on, 4'hF);
        chk("thr0_pe", power_enable, 4'hF);
        chk("thr0_busy", transition_busy, 1'b0);
        idle_threshold = 16'd10;
        tick(1);
        chk("thr_restore_busy", transition_busy, 1'b1);
        chk("thr_restore_active", active_domain, 2'd3);
        chk("thr_restore_iso", isolation_enable, 4'b1000);

        // always-on domain 0 idle with gate permission is never gated
        ao_gate_req = 4'b0001; ao_activity = 4'b1110;
        tick(40);
        chk("ao_domain_on", ao_domain_on, 4'hF);
        chk("ao_pe", ao_power_enable, 4'hF);
        chk("ao_iso", ao_isolation_enable, 4'h0);
        chk("ao_busy", ao_transition_busy, 1'b0);

        chk("no_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
